// File: rtl/sram_march_bist.sv
// March C- built-in self-test for a bit-wide synchronous SRAM.
// Drives the write/read ports of the memory and records the first miscompare and a saturating error count.
module sram_march_bist #(
    parameter int AW  = 1,
    parameter int ECW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic [AW-1:0]  fail_addr,
    output logic [2:0]     fail_elem,
    output logic [ECW-1:0] err_cnt,
    output logic           mem_we,
    output logic [AW-1:0]  mem_wa,
    output logic           mem_wd,
    output logic [AW-1:0]  mem_ra,
    input  logic           mem_rq
);

    typedef enum logic [3:0] {
        S_IDLE, S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_DONE
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST = '1;

    state_t         state_reg, state_next;
    logic [AW-1:0]  addr_reg, addr_next;
    logic           fail_reg, fail_next;
    logic [AW-1:0]  fail_addr_reg, fail_addr_next;
    logic [2:0]     fail_elem_reg, fail_elem_next;
    logic [ECW-1:0] err_cnt_reg, err_cnt_next;

    logic       in_run, desc, has_read, exp_val, we_dec, wd_dec;
    logic       succ_desc, last_addr, miscmp;
    logic [2:0] elem;
    state_t     succ;

    // Per-element operation decode: direction, expected read value and write data.
    always_comb begin
        elem      = 3'd0;
        desc      = 1'b0;
        has_read  = 1'b0;
        exp_val   = 1'b0;
        we_dec    = 1'b0;
        wd_dec    = 1'b0;
        in_run    = 1'b1;
        succ      = S_DONE;
        succ_desc = 1'b0;
        case (state_reg)
            S_E0: begin elem = 3'd0; we_dec = 1'b1; succ = S_E1; end
            S_E1: begin elem = 3'd1; has_read = 1'b1; we_dec = 1'b1; wd_dec = 1'b1; succ = S_E2; end
            S_E2: begin elem = 3'd2; has_read = 1'b1; exp_val = 1'b1; we_dec = 1'b1;
                        succ = S_E3; succ_desc = 1'b1; end
            S_E3: begin elem = 3'd3; desc = 1'b1; has_read = 1'b1; we_dec = 1'b1; wd_dec = 1'b1;
                        succ = S_E4; succ_desc = 1'b1; end
            S_E4: begin elem = 3'd4; desc = 1'b1; has_read = 1'b1; exp_val = 1'b1; we_dec = 1'b1;
                        succ = S_E5; end
            S_E5: begin elem = 3'd5; has_read = 1'b1; succ = S_DONE; end
            default: in_run = 1'b0;
        endcase
    end

    assign last_addr = desc ? (addr_reg == '0) : (addr_reg == ADDR_LAST);
    assign miscmp    = has_read && (mem_rq != exp_val);

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        fail_next      = fail_reg;
        fail_addr_next = fail_addr_reg;
        fail_elem_next = fail_elem_reg;
        err_cnt_next   = err_cnt_reg;
        if (!in_run) begin
            if (start) begin
                state_next     = S_E0;
                addr_next      = '0;
                fail_next      = 1'b0;
                fail_addr_next = '0;
                fail_elem_next = 3'd0;
                err_cnt_next   = '0;
            end
        end else begin
            if (miscmp) begin
                if (err_cnt_reg != '1)
                    err_cnt_next = err_cnt_reg + ECW'(1);
                if (!fail_reg) begin
                    fail_next      = 1'b1;
                    fail_addr_next = addr_reg;
                    fail_elem_next = elem;
                end
            end
            if (last_addr) begin
                state_next = succ;
                addr_next  = succ_desc ? ADDR_LAST : '0;
            end else begin
                addr_next  = desc ? (addr_reg - AW'(1)) : (addr_reg + AW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
            fail_elem_reg <= 3'd0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            fail_reg      <= fail_next;
            fail_addr_reg <= fail_addr_next;
            fail_elem_reg <= fail_elem_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    // Memory controls are pure state decode, so reset drops mem_we without waiting for a clock.
    assign busy      = in_run;
    assign done      = (state_reg == S_DONE);
    assign fail      = fail_reg;
    assign fail_addr = fail_addr_reg;
    assign fail_elem = fail_elem_reg;
    assign err_cnt   = err_cnt_reg;
    assign mem_we    = we_dec;
    assign mem_wd    = wd_dec;
    assign mem_wa    = in_run ? addr_reg : '0;
    assign mem_ra    = in_run ? addr_reg : '0;

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist: AW=1 and AW=3 instances against faulty SRAM models.
module tb_sram_march_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, st1, st3;
    logic b1, dn1, f1, we1, wd1, rq1;
    logic [0:0] fa1, wa1, ra1;
    logic [2:0] fe1;
    logic [3:0] ec1;
    logic b3, dn3, f3, we3, wd3, rq3;
    logic [2:0] fa3, wa3, ra3, fe3;
    logic [3:0] ec3;

    sram_march_bist #(.AW(1), .ECW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .busy(b1), .done(dn1), .fail(f1),
        .fail_addr(fa1), .fail_elem(fe1), .err_cnt(ec1), .mem_we(we1), .mem_wa(wa1),
        .mem_wd(wd1), .mem_ra(ra1), .mem_rq(rq1));

    sram_march_bist #(.AW(3), .ECW(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .busy(b3), .done(dn3), .fail(f3),
        .fail_addr(fa3), .fail_elem(fe3), .err_cnt(ec3), .mem_we(we3), .mem_wa(wa3),
        .mem_wd(wd3), .mem_ra(ra3), .mem_rq(rq3));

    // Bench-side SRAMs: stored bits plus stuck-at-0 / stuck-at-1 masks applied on read.
    logic       m1 [2];
    logic       m3 [8];
    logic [7:0] sa0, sa1;
    assign rq1 = (m1[ra1] & ~sa0[ra1]) | sa1[ra1];
    assign rq3 = (m3[ra3] & ~sa0[ra3]) | sa1[ra3];
    always @(posedge clk) begin
        if (we1) m1[wa1] <= wd1;
        if (we3) m3[wa3] <= wd3;
    end

    int sel;
    logic t_busy, t_done, t_fail, t_we, t_wd;
    logic [2:0] t_fa, t_fe, t_wa, t_ra;
    logic [3:0] t_ec;
    always_comb begin
        t_busy = (sel != 0) ? b3  : b1;
        t_done = (sel != 0) ? dn3 : dn1;
        t_fail = (sel != 0) ? f3  : f1;
        t_we   = (sel != 0) ? we3 : we1;
        t_wd   = (sel != 0) ? wd3 : wd1;
        t_fa   = (sel != 0) ? fa3 : {2'b00, fa1};
        t_fe   = (sel != 0) ? fe3 : fe1;
        t_wa   = (sel != 0) ? wa3 : {2'b00, wa1};
        t_ra   = (sel != 0) ? ra3 : {2'b00, ra1};
        t_ec   = (sel != 0) ? ec3 : ec1;
    end

    typedef struct {
        int we; int addr; int wd; int rd; int cnt; int f; int fa; int fe;
    } step_t;
    step_t q[$];

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;
    int fin_cnt, fin_raw, fin_f, fin_fa, fin_fe;
    int fin_mem[8];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // March C- reference: walk elements over an abstract cell array, recording the
    // expected per-cycle bus activity and the running result registers.
    function automatic void build(input int n, input logic [7:0] s0, input logic [7:0] s1,
                                  input logic [7:0] init);
        bit cur[8];
        int cnt, raw, f, fa, fe, a;
        bit eff, rv, wv;
        step_t st;
        for (int i = 0; i < 8; i++) cur[i] = init[i];
        cnt = 0; raw = 0; f = 0; fa = 0; fe = 0;
        q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a  = (e == 3 || e == 4) ? n - 1 - k : k;
                wv = (e == 1 || e == 3);
                rv = (e == 2 || e == 4);
                st.we = (e < 5) ? 1 : 0;
                st.addr = a;
                st.wd = (e < 5) ? int'(wv) : 0;
                st.rd = (e > 0) ? 1 : 0;
                st.cnt = cnt; st.f = f; st.fa = fa; st.fe = fe;
                q.push_back(st);
                if (e > 0) begin
                    eff = (cur[a] & ~s0[a]) | s1[a];
                    if (eff != rv) begin
                        raw++;
                        if (cnt < 15) cnt++;
                        if (f == 0) begin f = 1; fa = a; fe = e; end
                    end
                end
                if (e < 5) cur[a] = wv;
            end
        end
        fin_cnt = cnt; fin_raw = raw; fin_f = f; fin_fa = fa; fin_fe = fe;
        for (int i = 0; i < 8; i++) fin_mem[i] = int'(cur[i]);
    endfunction

    always @(negedge clk) begin : compare
        step_t e;
        if (armed && q.size() > 0) begin
            e = q.pop_front();
            chk("run_busy", int'(t_busy), 1);
            chk("run_done", int'(t_done), 0);
            chk("run_we", int'(t_we), e.we);
            if (e.we != 0) begin
                chk("run_wa", int'(t_wa), e.addr);
                chk("run_wd", int'(t_wd), e.wd);
            end
            if (e.rd != 0) chk("run_ra", int'(t_ra), e.addr);
            chk("run_fail", int'(t_fail), e.f);
            chk("run_err_cnt", int'(t_ec), e.cnt);
            if (e.f != 0) begin
                chk("run_fail_addr", int'(t_fa), e.fa);
                chk("run_fail_elem", int'(t_fe), e.fe);
            end
        end
    end

    task automatic pulse_start(input int s);
        if (s != 0) st3 = 1'b1; else st1 = 1'b1;
        @(posedge clk);
        #1;
        st1 = 1'b0;
        st3 = 1'b0;
    endtask

    task automatic run(input int s, input logic [7:0] f0, input logic [7:0] f1m, input bit mid);
        logic [7:0] init;
        int n, guard;
        n = (s != 0) ? 8 : 2;
        sel = s; sa0 = f0; sa1 = f1m;
        init = '0;
        for (int i = 0; i < n; i++) init[i] = (s != 0) ? m3[i] : m1[i];
        build(n, f0, f1m, init);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        pulse_start(s);
        armed = 1'b1;
        if (mid) begin
            repeat (4) @(negedge clk);
            #1;
            pulse_start(s);
        end
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            chk("run_timeout", q.size(), 0);
            q.delete();
        end
        armed = 1'b0;
        @(negedge clk);
        chk("end_busy", int'(t_busy), 0);
        chk("end_done", int'(t_done), 1);
        chk("end_fail", int'(t_fail), fin_f);
        chk("end_err_cnt", int'(t_ec), fin_cnt);
        chk("end_fail_addr", int'(t_fa), fin_fa);
        chk("end_fail_elem", int'(t_fe), fin_fe);
        chk("end_we", int'(t_we), 0);
        chk("end_wa", int'(t_wa), 0);
        chk("end_ra", int'(t_ra), 0);
        for (int i = 0; i < n; i++)
            chk("end_mem", (s != 0) ? int'(m3[i]) : int'(m1[i]), fin_mem[i]);
        repeat (2) @(negedge clk);
        chk("hold_done", int'(t_done), 1);
        chk("hold_err_cnt", int'(t_ec), fin_cnt);
    endtask

    initial begin
        logic [7:0] r0, r1;
        int s;
        rst_n = 1'b1; st1 = 1'b0; st3 = 1'b0; sel = 0; sa0 = '0; sa1 = '0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_busy1", int'(b1), 0);
        chk("rst_done1", int'(dn1), 0);
        chk("rst_fail1", int'(f1), 0);
        chk("rst_err_cnt1", int'(ec1), 0);
        chk("rst_we1", int'(we1), 0);
        chk("rst_busy3", int'(b3), 0);
        chk("rst_we3", int'(we3), 0);
        @(negedge clk) rst_n = 1'b1;

        // Good memory: clean run, final cells 0,0.
        run(0, 8'h00, 8'h00, 1'b0);
        chk("lit_good_fail", int'(f1), 0);
        chk("lit_good_err_cnt", int'(ec1), 0);
        chk("lit_good_mem0", int'(m1[0]), 0);
        chk("lit_good_mem1", int'(m1[1]), 0);

        // Cell 1 stuck-at-0.
        run(0, 8'h02, 8'h00, 1'b0);
        chk("lit_sa0_fail", int'(f1), 1);
        chk("lit_sa0_fail_addr", int'(fa1), 1);
        chk("lit_sa0_fail_elem", int'(fe1), 2);
        chk("lit_sa0_err_cnt", int'(ec1), 2);

        // Cell 0 stuck-at-1; start from DONE with fail set must clear results.
        run(0, 8'h00, 8'h01, 1'b0);
        chk("lit_sa1_fail_addr", int'(fa1), 0);
        chk("lit_sa1_fail_elem", int'(fe1), 1);
        chk("lit_sa1_err_cnt", int'(ec1), 3);

        // Start pulsed mid-run is ignored.
        run(0, 8'h00, 8'h00, 1'b1);
        chk("lit_mid_err_cnt", int'(ec1), 0);

        // Asynchronous reset mid-run.
        sel = 0; sa0 = '0; sa1 = '0;
        build(2, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        pulse_start(0);
        armed = 1'b1;
        repeat (6) @(negedge clk);
        armed = 1'b0;
        q.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", int'(b1), 0);
        chk("async_we", int'(we1), 0);
        chk("async_done", int'(dn1), 0);
        @(negedge clk) rst_n = 1'b1;
        run(0, 8'h00, 8'h00, 1'b0);

        // AW=3, every cell stuck-at-1: 24 miscompares, counter saturates.
        run(1, 8'h00, 8'hFF, 1'b0);
        chk("lit_model_raw", fin_raw, 24);
        chk("lit_sat_err_cnt", int'(ec3), 15);
        chk("lit_sat_fail_addr", int'(fa3), 0);
        chk("lit_sat_fail_elem", int'(fe3), 1);

        // Randomized fault maps on both sizes.
        for (int it = 0; it < 8; it++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            s = int'($urandom_range(0, 1));
            run(s, r0 & ~r1 & 8'($urandom), r1 & ~r0 & 8'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
